// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  // Common-anode segments are active-low, so an all-ones pattern is dark.
  localparam int unsigned SEG_W      = 7;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam int unsigned MIN_DIGITS = 2;
  localparam int unsigned MAX_DIGITS = 8;

  // Width of a down-counter able to hold the larger of two durations.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter that times both the SHOW and BLANK phases.
module seg_scan_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done_c,
  output logic          near_c
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // done marks the final cycle of a phase; near marks the cycle before it.
  assign done_c = (cnt_q == '0);
  assign near_c = (cnt_q == CW'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner: per-digit value registers, one shared decoder
// input, blank gaps between digits and decoder-aligned one-hot digit enables.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned PRESCALE     = 1000,
  parameter int unsigned BLANK_CYCLES = 2,
  parameter int unsigned DEC_LAT      = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        lz_blank,
  input  logic                        wr_en,
  input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
  input  logic [DW-1:0]               wr_data,
  output logic [DW-1:0]               dec_value,
  output logic [N_DIGITS-1:0]         digit_sel,
  output logic                        frame_tick
);

  localparam int unsigned AW       = $clog2(N_DIGITS);
  localparam int unsigned CW       = cnt_width(PRESCALE, BLANK_CYCLES);
  localparam bit          HAS_GAP  = (BLANK_CYCLES > 0);
  localparam bit          GAP_ONE  = (BLANK_CYCLES == 1);
  localparam bit          SHOW_ONE = (PRESCALE == 1);
  localparam logic [AW-1:0] LAST      = AW'(N_DIGITS - 1);
  localparam logic [CW-1:0] SHOW_LOAD = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(HAS_GAP ? BLANK_CYCLES - 1 : 0);

  scan_state_t         state_q;
  logic [AW-1:0]       idx_q;
  logic [N_DIGITS-1:0] sel_q;
  logic [DW-1:0]       digit_q [N_DIGITS];

  logic [N_DIGITS-1:0] zero_from_c;
  logic [AW-1:0]       idx_adv_c;
  logic [N_DIGITS-1:0] sel_adv_c;
  logic                tmr_load_c;
  logic [CW-1:0]       tmr_val_c;
  logic                tmr_done_c;
  logic                tmr_near_c;

  // Digit registers accept writes in every state; out-of-range addresses drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_DIGITS); i++) digit_q[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < 32'(N_DIGITS))) begin
      digit_q[wr_addr] <= wr_data;
    end
  end

  // zero_from_c[k]: every digit at position k and above holds zero.
  always_comb begin
    logic acc;
    acc         = 1'b1;
    zero_from_c = '0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      acc            = acc & (digit_q[k] == '0);
      zero_from_c[k] = acc;
    end
  end

  // Enable for the next digit; digit 0 always lights so a zero value shows "0".
  always_comb begin
    idx_adv_c = (idx_q == LAST) ? '0 : idx_q + AW'(1);
    sel_adv_c = N_DIGITS'(1) << idx_adv_c;
    if (lz_blank && (idx_adv_c != '0) && zero_from_c[idx_adv_c]) sel_adv_c = '0;
  end

  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = SHOW_LOAD;
        end
      end
      SHOW: begin
        if (!enable) begin
          tmr_load_c = 1'b1;
        end else if (tmr_done_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = HAS_GAP ? GAP_LOAD : SHOW_LOAD;
        end
      end
      BLANK: begin
        if (!enable) begin
          tmr_load_c = 1'b1;
        end else if (tmr_done_c) begin
          tmr_load_c = 1'b1;
          tmr_val_c  = SHOW_LOAD;
        end
      end
      default: tmr_load_c = 1'b1;
    endcase
  end

  seg_scan_timer #(.CW(CW)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .done_c   (tmr_done_c),
    .near_c   (tmr_near_c)
  );

  // Scan FSM; frame_tick is set one edge early so it lands on the slot's last cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sel_q      <= '0;
      dec_value  <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      unique case (state_q)
        IDLE: begin
          sel_q <= '0;
          if (enable) begin
            state_q   <= SHOW;
            idx_q     <= '0;
            dec_value <= digit_q[0];
            sel_q     <= N_DIGITS'(1);
          end
        end
        SHOW: begin
          if (!enable) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
          end else if (tmr_done_c) begin
            if (HAS_GAP) begin
              state_q    <= BLANK;
              sel_q      <= '0;
              frame_tick <= GAP_ONE && (idx_q == LAST);
            end else begin
              idx_q      <= idx_adv_c;
              dec_value  <= digit_q[idx_adv_c];
              sel_q      <= sel_adv_c;
              frame_tick <= SHOW_ONE && (idx_adv_c == LAST);
            end
          end else begin
            frame_tick <= !HAS_GAP && (idx_q == LAST) && tmr_near_c;
          end
        end
        BLANK: begin
          if (!enable) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sel_q   <= '0;
          end else if (tmr_done_c) begin
            state_q    <= SHOW;
            idx_q      <= idx_adv_c;
            dec_value  <= digit_q[idx_adv_c];
            sel_q      <= sel_adv_c;
            frame_tick <= !HAS_GAP && SHOW_ONE && (idx_adv_c == LAST);
          end else begin
            frame_tick <= (idx_q == LAST) && tmr_near_c;
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          sel_q   <= '0;
        end
      endcase
    end
  end

  // Delay the enables to line up with the decoder's registered segment output.
  if (DEC_LAT == 0) begin : g_no_pipe
    assign digit_sel = sel_q;
  end else begin : g_pipe
    logic [N_DIGITS-1:0] pipe_q [DEC_LAT];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < int'(DEC_LAT); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= sel_q;
        for (int i = 1; i < int'(DEC_LAT); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign digit_sel = pipe_q[DEC_LAT-1];
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: cycle-exact scan checks plus a display-event scoreboard.
module tb_seg_scan_ctrl;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       lz_blank;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] dec_value;
  logic [3:0] digit_sel;
  logic       frame_tick;

  typedef struct {
    logic [7:0] dec;
    logic [3:0] sel;
  } ev_t;

  ev_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  seg_scan_ctrl #(
    .N_DIGITS     (4),
    .DW           (8),
    .PRESCALE     (4),
    .BLANK_CYCLES (1),
    .DEC_LAT      (1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .lz_blank   (lz_blank),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dec_value  (dec_value),
    .digit_sel  (digit_sel),
    .frame_tick (frame_tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_digit(input logic [1:0] a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic push_ev(input logic [7:0] d, input logic [3:0] s);
    ev_t e;
    e.dec = d;
    e.sel = s;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb_q.size() == 0) break;
      step(1);
    end
    check("sb_drain", 32'(sb_q.size()), 32'(0));
  endtask

  // Each time a digit lights, it must match the next expected display event.
  logic [3:0] prev_sel;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_sel = 4'b0;
    end else begin
      check("onehot0", 32'($onehot0(digit_sel)), 32'(1));
      if (digit_sel != 4'b0 && digit_sel != prev_sel) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(digit_sel), 32'(0));
        end else begin
          ev_t e;
          e = sb_q.pop_front();
          check("ev_sel", 32'(digit_sel), 32'(e.sel));
          check("ev_dec", 32'(dec_value), 32'(e.dec));
        end
      end
      prev_sel = digit_sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    lz_blank = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 8'd0;
    step(3);
    check("rst_dec", 32'(dec_value), 32'(0));
    check("rst_sel", 32'(digit_sel), 32'(0));
    check("rst_tick", 32'(frame_tick), 32'(0));
    reset_n = 1'b1;
    step(1);

    // Reset asserted mid-SHOW clears outputs immediately and digit registers.
    for (int i = 0; i < 4; i++) write_digit(2'(i), 8'h09);
    push_ev(8'h09, 4'b0001);
    enable = 1'b1;
    step(3);
    check("pre_rst_sel", 32'(digit_sel), 32'(4'b0001));
    check("pre_rst_dec", 32'(dec_value), 32'(8'h09));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sel", 32'(digit_sel), 32'(0));
    check("async_rst_dec", 32'(dec_value), 32'(0));
    check("async_rst_tick", 32'(frame_tick), 32'(0));
    enable = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < 4; i++) push_ev(8'h00, 4'(1 << i));
    enable = 1'b1;
    wait_drain(40);
    enable = 1'b0;
    step(3);

    // Two full frames checked cycle by cycle.
    for (int i = 0; i < 4; i++) write_digit(2'(i), 8'(i + 1));
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) push_ev(8'(i + 1), 4'(1 << i));
    enable = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] exp_sel;
      int         ps;
      step(1);
      ps      = t - 1;
      exp_sel = 4'b0;
      if (t > 0 && (ps % 5) < 4) exp_sel = 4'(1 << ((ps / 5) % 4));
      check("scan_sel", 32'(digit_sel), 32'(exp_sel));
      check("scan_dec", 32'(dec_value), 32'(((t / 5) % 4) + 1));
      check("scan_tick", 32'(frame_tick), 32'((t % 20) == 19));
    end
    enable = 1'b0;
    step(3);
    check("scan_drain", 32'(sb_q.size()), 32'(0));

    // Leading-zero suppression: 0,0,5,0 then all zeros.
    lz_blank = 1'b1;
    write_digit(2'd0, 8'd0);
    write_digit(2'd1, 8'd5);
    write_digit(2'd2, 8'd0);
    write_digit(2'd3, 8'd0);
    for (int f = 0; f < 2; f++) begin
      push_ev(8'd0, 4'b0001);
      push_ev(8'd5, 4'b0010);
    end
    enable = 1'b1;
    step(40);
    enable = 1'b0;
    step(3);
    check("lz_drain", 32'(sb_q.size()), 32'(0));
    write_digit(2'd1, 8'd0);
    push_ev(8'd0, 4'b0001);
    push_ev(8'd0, 4'b0001);
    enable = 1'b1;
    step(40);
    enable = 1'b0;
    step(3);
    check("lz_zero_drain", 32'(sb_q.size()), 32'(0));
    lz_blank = 1'b0;

    // A write to the digit being shown takes effect on its next visit.
    for (int i = 0; i < 4; i++) write_digit(2'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) push_ev(8'(i + 1), 4'(1 << i));
    push_ev(8'd1, 4'b0001);
    push_ev(8'd7, 4'b0010);
    push_ev(8'd3, 4'b0100);
    push_ev(8'd4, 4'b1000);
    enable = 1'b1;
    step(7);
    check("mid_show_dec", 32'(dec_value), 32'(2));
    write_digit(2'd1, 8'd7);
    check("held_dec", 32'(dec_value), 32'(2));
    step(32);
    enable = 1'b0;
    step(3);
    check("wr_show_drain", 32'(sb_q.size()), 32'(0));

    // Disable during digit 2, then restart from digit 0.
    push_ev(8'd1, 4'b0001);
    push_ev(8'd7, 4'b0010);
    push_ev(8'd3, 4'b0100);
    enable = 1'b1;
    step(12);
    check("dis_pre_sel", 32'(digit_sel), 32'(4'b0100));
    enable = 1'b0;
    step(1);
    check("dis_lag_sel", 32'(digit_sel), 32'(4'b0100));
    check("dis_lag_tick", 32'(frame_tick), 32'(0));
    step(1);
    check("dis_dark_sel", 32'(digit_sel), 32'(0));
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_tick", 32'(frame_tick), 32'(0));
      check("idle_sel", 32'(digit_sel), 32'(0));
    end
    push_ev(8'd1, 4'b0001);
    enable = 1'b1;
    step(1);
    check("restart_dec", 32'(dec_value), 32'(1));
    check("restart_sel_lag", 32'(digit_sel), 32'(0));
    step(1);
    check("restart_sel", 32'(digit_sel), 32'(4'b0001));
    enable = 1'b0;
    step(3);
    check("final_drain", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
